// File: rtl/ysyx_22050078_lsu_ctrl_pkg.sv
// Shared LSU types: FSM state codes, access-size codes and mask/alignment helpers.
// Combinational helpers only; no flow control lives here.
package ysyx_22050078_lsu_ctrl_pkg;

   localparam int CPU_WIDTH = 64;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      m = 8'h01;
      case (sz)
         SZ_BYTE:  m = 8'h01;
         SZ_HALF:  m = 8'h03;
         SZ_WORD:  m = 8'h0F;
         SZ_DWORD: m = 8'hFF;
         default:  m = 8'h01;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
      logic mis;
      mis = 1'b0;
      case (sz)
         SZ_HALF:  mis = off[0];
         SZ_WORD:  mis = |off[1:0];
         SZ_DWORD: mis = |off;
         default:  mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_22050078_lsu_ext.sv
// Load data alignment: shift the bus word down by the byte offset, truncate to size, sign/zero-extend.
// Purely combinational; also used by the WB bypass path.
module ysyx_22050078_lsu_ext
   import ysyx_22050078_lsu_ctrl_pkg::*;
#(
   parameter int DW = CPU_WIDTH
) (
   input  logic [DW-1:0] rdata,
   input  logic [2:0]    off,
   input  logic [2:0]    func3,
   output logic [DW-1:0] data
);

   logic [DW-1:0] sh;
   logic          sgn_en;

   assign sh     = rdata >> {off, 3'b000};
   assign sgn_en = ~func3[2];

   always_comb begin
      data = sh;
      case (func3[1:0])
         SZ_BYTE:  data = {{(DW-8){sgn_en & sh[7]}},  sh[7:0]};
         SZ_HALF:  data = {{(DW-16){sgn_en & sh[15]}}, sh[15:0]};
         SZ_WORD:  data = {{(DW-32){sgn_en & sh[31]}}, sh[31:0]};
         SZ_DWORD: data = sh;
         default:  data = sh;
      endcase
   end

endmodule

// File: rtl/ysyx_22050078_lsu_ctrl.sv
// LSU sequencer: store 3 cycles, load 4+, stalling upstream until the valid/ready bus access completes.
// YSYX_22050078_LSU_MISALIGN_EN adds o_misalign and skips the bus for misaligned accesses.
module ysyx_22050078_lsu_ctrl
   import ysyx_22050078_lsu_ctrl_pkg::*;
#(
   parameter int DW   = CPU_WIDTH,
   parameter int MSKW = DW / 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_ld_en,
   input  logic            i_st_en,
   input  logic [2:0]      i_func3,
   input  logic [DW-1:0]   i_addr,
   input  logic [DW-1:0]   i_wdata,
   output logic            o_stall,
   output logic            o_mem_valid,
   output logic            o_mem_wen,
   output logic [DW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [MSKW-1:0] o_mem_wmask,
   input  logic            i_mem_ready,
   input  logic            i_mem_rvalid,
   input  logic [DW-1:0]   i_mem_rdata,
`ifdef YSYX_22050078_LSU_MISALIGN_EN
   output logic            o_misalign,
`endif
   output logic [DW-1:0]   o_ld_data,
   output logic            o_ld_valid
);

   lsu_state_e      state, state_nxt;
   logic            latch, capture;
   logic            mis_now, mis_q;
   logic            is_ld_q;
   logic [2:0]      off_q, func3_q;
   logic [DW-1:0]   addr_q, wdata_q, ld_data_q, ext_data;
   logic [MSKW-1:0] wmask_q, wmask_now;

   assign wmask_now = MSKW'(size_mask(i_func3[1:0])) << i_addr[2:0];

`ifdef YSYX_22050078_LSU_MISALIGN_EN
   assign mis_now    = misaligned(i_func3[1:0], i_addr[2:0]);
   assign o_misalign = (state == LSU_DONE) & mis_q;
`else
   assign mis_now = 1'b0;
`endif

   ysyx_22050078_lsu_ext #(.DW(DW)) u_ext (
      .rdata (i_mem_rdata),
      .off   (off_q),
      .func3 (func3_q),
      .data  (ext_data)
   );

   always_comb begin
      state_nxt = state;
      o_stall   = 1'b0;
      latch     = 1'b0;
      capture   = 1'b0;
      case (state)
         LSU_IDLE: begin
            if (i_ld_en | i_st_en) begin
               o_stall   = 1'b1;
               latch     = 1'b1;
               state_nxt = mis_now ? LSU_DONE : LSU_REQ;
            end
         end
         LSU_REQ: begin
            o_stall = 1'b1;
            if (i_mem_ready) state_nxt = is_ld_q ? LSU_WAIT : LSU_DONE;
         end
         LSU_WAIT: begin
            o_stall = 1'b1;
            if (i_mem_rvalid) begin
               capture   = 1'b1;
               state_nxt = LSU_DONE;
            end
         end
         // Always back to IDLE: the en bits seen here belong to the finished access.
         LSU_DONE: state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LSU_IDLE;
         is_ld_q   <= 1'b0;
         mis_q     <= 1'b0;
         off_q     <= '0;
         func3_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         ld_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            // Load takes priority when both enables are set; the store is dropped.
            is_ld_q <= i_ld_en;
            mis_q   <= mis_now;
            off_q   <= i_addr[2:0];
            func3_q <= i_func3;
            addr_q  <= {i_addr[DW-1:3], 3'b000};
            wdata_q <= i_wdata << {i_addr[2:0], 3'b000};
            wmask_q <= i_ld_en ? '0 : wmask_now;
         end
         if (capture) ld_data_q <= ext_data;
      end
   end

   assign o_mem_valid = (state == LSU_REQ);
   assign o_mem_wen   = (state == LSU_REQ) & ~is_ld_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_wmask = wmask_q;
   assign o_ld_data   = ld_data_q;
   assign o_ld_valid  = (state == LSU_DONE) & is_ld_q & ~mis_q;

endmodule

// File: tb/tb_ysyx_22050078_lsu_ctrl.sv
// Directed bench for the LSU sequencer with hand-computed expectations.
module tb_ysyx_22050078_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ld_en, st_en;
   logic [2:0]  func3;
   logic [63:0] addr, wdata;
   logic        stall, mem_valid, mem_wen;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ready, mem_rvalid;
   logic [63:0] mem_rdata;
   logic [63:0] ld_data;
   logic        ld_valid;
`ifdef YSYX_22050078_LSU_MISALIGN_EN
   logic        misalign;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   ysyx_22050078_lsu_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_ld_en      (ld_en),
      .i_st_en      (st_en),
      .i_func3      (func3),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_stall      (stall),
      .o_mem_valid  (mem_valid),
      .o_mem_wen    (mem_wen),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_wmask  (mem_wmask),
      .i_mem_ready  (mem_ready),
      .i_mem_rvalid (mem_rvalid),
      .i_mem_rdata  (mem_rdata),
`ifdef YSYX_22050078_LSU_MISALIGN_EN
      .o_misalign   (misalign),
`endif
      .o_ld_data    (ld_data),
      .o_ld_valid   (ld_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic do_store(input string tag, input logic [63:0] a, input logic [2:0] f3,
                           input logic [63:0] wd, input logic [7:0] exp_mask,
                           input logic [63:0] exp_wdata);
      @(negedge clk);
      st_en = 1'b1; addr = a; func3 = f3; wdata = wd;
      #1;
      chk({tag, "/idle_stall"}, {63'd0, stall}, 64'd1);
      chk({tag, "/idle_valid"}, {63'd0, mem_valid}, 64'd0);
      @(negedge clk); #1;
      chk({tag, "/req_valid"}, {63'd0, mem_valid}, 64'd1);
      chk({tag, "/req_wen"},   {63'd0, mem_wen}, 64'd1);
      chk({tag, "/req_stall"}, {63'd0, stall}, 64'd1);
      chk({tag, "/addr"},      mem_addr, {a[63:3], 3'b000});
      chk({tag, "/wmask"},     {56'd0, mem_wmask}, {56'd0, exp_mask});
      chk({tag, "/wdata"},     mem_wdata, exp_wdata);
      @(negedge clk); #1;
      chk({tag, "/done_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, "/done_valid"}, {63'd0, mem_valid}, 64'd0);
      chk({tag, "/done_ldv"},   {63'd0, ld_valid}, 64'd0);
      @(negedge clk);
      st_en = 1'b0;
      #1;
      chk({tag, "/after_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, "/after_valid"}, {63'd0, mem_valid}, 64'd0);
   endtask

   task automatic do_load(input string tag, input logic [63:0] a, input logic [2:0] f3,
                          input logic [63:0] rd, input logic [63:0] exp_d);
      @(negedge clk);
      ld_en = 1'b1; addr = a; func3 = f3;
      #1;
      chk({tag, "/idle_stall"}, {63'd0, stall}, 64'd1);
      @(negedge clk); #1;
      chk({tag, "/req_valid"}, {63'd0, mem_valid}, 64'd1);
      chk({tag, "/req_wen"},   {63'd0, mem_wen}, 64'd0);
      chk({tag, "/addr"},      mem_addr, {a[63:3], 3'b000});
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = rd;
      #1;
      chk({tag, "/wait_stall"}, {63'd0, stall}, 64'd1);
      chk({tag, "/wait_valid"}, {63'd0, mem_valid}, 64'd0);
      chk({tag, "/wait_ldv"},   {63'd0, ld_valid}, 64'd0);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      #1;
      chk({tag, "/done_ldv"},   {63'd0, ld_valid}, 64'd1);
      chk({tag, "/done_data"},  ld_data, exp_d);
      chk({tag, "/done_stall"}, {63'd0, stall}, 64'd0);
      @(negedge clk);
      ld_en = 1'b0;
      #1;
      chk({tag, "/pulse_end"}, {63'd0, ld_valid}, 64'd0);
      chk({tag, "/held_data"}, ld_data, exp_d);
   endtask

   initial begin
      rst_n = 1'b0;
      ld_en = 1'b0; st_en = 1'b0; func3 = 3'd0; addr = '0; wdata = '0;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
      #2;
      chk("rst/stall", {63'd0, stall}, 64'd0);
      chk("rst/valid", {63'd0, mem_valid}, 64'd0);
      chk("rst/wen",   {63'd0, mem_wen}, 64'd0);
      chk("rst/addr",  mem_addr, 64'd0);
      chk("rst/wdata", mem_wdata, 64'd0);
      chk("rst/wmask", {56'd0, mem_wmask}, 64'd0);
      chk("rst/ldd",   ld_data, 64'd0);
      chk("rst/ldv",   {63'd0, ld_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_store("sd", 64'h8000_0008, 3'b011, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
      do_store("sb", 64'h8000_0003, 3'b000, 64'h0000_0000_0000_00AB, 8'h08, 64'h0000_0000_AB00_0000);
      do_store("sh", 64'h8000_0006, 3'b001, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000);
      do_store("sw", 64'h8000_0004, 3'b010, 64'h0000_0000_1234_5678, 8'hF0, 64'h1234_5678_0000_0000);
      do_load("lb",  64'h8000_0005, 3'b000, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("lbu", 64'h8000_0005, 3'b100, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080);
      do_load("lh",  64'h8000_0006, 3'b001, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
      do_load("lwu", 64'h8000_0004, 3'b110, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF);
      do_load("lw",  64'h8000_0004, 3'b010, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_DEAD_BEEF);
      do_load("f111", 64'h8000_0000, 3'b111, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9);

      // Both enables: the load is performed, the store is dropped.
      @(negedge clk);
      ld_en = 1'b1; st_en = 1'b1; addr = 64'h8000_0010; func3 = 3'b011; wdata = 64'hFFFF;
      @(negedge clk); #1;
      chk("both/valid", {63'd0, mem_valid}, 64'd1);
      chk("both/wen",   {63'd0, mem_wen}, 64'd0);
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_0042;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("both/ldv",  {63'd0, ld_valid}, 64'd1);
      chk("both/data", ld_data, 64'h42);
      @(negedge clk);
      ld_en = 1'b0; st_en = 1'b0;

      // Load with a slow bus: ready low 5 cycles, rvalid 3 cycles into WAIT.
      @(negedge clk);
      ld_en = 1'b1; addr = 64'h8000_0018; func3 = 3'b011; mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("slow/req_valid", {63'd0, mem_valid}, 64'd1);
         chk("slow/req_addr",  mem_addr, 64'h8000_0018);
         chk("slow/req_stall", {63'd0, stall}, 64'd1);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("slow/hs_valid", {63'd0, mem_valid}, 64'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         chk("slow/wait_stall", {63'd0, stall}, 64'd1);
         chk("slow/wait_valid", {63'd0, mem_valid}, 64'd0);
      end
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("slow/wait3_stall", {63'd0, stall}, 64'd1);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("slow/ldv",   {63'd0, ld_valid}, 64'd1);
      chk("slow/data",  ld_data, 64'h0123_4567_89AB_CDEF);
      chk("slow/stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      ld_en = 1'b0;

      // Reset asserted while the load sits in WAIT.
      @(negedge clk);
      ld_en = 1'b1; addr = 64'h8000_0020; func3 = 3'b011;
      @(negedge clk);
      @(negedge clk); #1;
      chk("arst/pre_stall", {63'd0, stall}, 64'd1);
      rst_n = 1'b0; ld_en = 1'b0;
      #1;
      chk("arst/stall", {63'd0, stall}, 64'd0);
      chk("arst/valid", {63'd0, mem_valid}, 64'd0);
      chk("arst/addr",  mem_addr, 64'd0);
      chk("arst/wdata", mem_wdata, 64'd0);
      chk("arst/wmask", {56'd0, mem_wmask}, 64'd0);
      chk("arst/ldd",   ld_data, 64'd0);
      chk("arst/ldv",   {63'd0, ld_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_store("post_rst", 64'h8000_0030, 3'b011, 64'hCAFE_F00D_0000_0001, 8'hFF, 64'hCAFE_F00D_0000_0001);

`ifdef YSYX_22050078_LSU_MISALIGN_EN
      @(negedge clk);
      ld_en = 1'b1; addr = 64'h8000_0002; func3 = 3'b010;
      #1;
      chk("mis/idle_stall", {63'd0, stall}, 64'd1);
      chk("mis/idle_flag",  {63'd0, misalign}, 64'd0);
      @(negedge clk); #1;
      chk("mis/valid", {63'd0, mem_valid}, 64'd0);
      chk("mis/flag",  {63'd0, misalign}, 64'd1);
      chk("mis/ldv",   {63'd0, ld_valid}, 64'd0);
      chk("mis/stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      ld_en = 1'b0;
      #1;
      chk("mis/flag_end", {63'd0, misalign}, 64'd0);
      chk("mis/valid_end", {63'd0, mem_valid}, 64'd0);
`else
      do_store("sw_mis", 64'h8000_0006, 3'b010, 64'h0000_0000_1234_5678, 8'hC0, 64'h5678_0000_0000_0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
